// File: rtl/am_rx_pkg.sv
// Shared definitions for the AM key receiver: FSM states, slot layout and width helpers.
package am_rx_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RX   = 2'd1,
        DONE = 2'd2
    } rx_state_t;

    localparam int SYNC_SLOT     = 0;
    localparam int DATA_SLOT     = 2;
    localparam int SLOTS_PER_BIT = 8;

    function automatic int count_width(input int win_log2);
        return win_log2 + 1;
    endfunction

    function automatic int vote_width(input int windows_per_slot);
        return $clog2(windows_per_slot + 1);
    endfunction

    function automatic int idx_width(input int slot_log2, input int win_log2);
        return $clog2(SLOTS_PER_BIT) + slot_log2 - win_log2;
    endfunction

endpackage

// File: rtl/am_carrier_detect.sv
// Synchronizes rf_in and counts high samples per 2^WIN_LOG2-clock window;
// mark and win_end are registered and valid together for one clock per window.
module am_carrier_detect
    import am_rx_pkg::*;
#(
    parameter int WIN_LOG2 = 16,
    parameter int MARK_MIN = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic rf_in,
    output logic mark,
    output logic win_end
);

    localparam int CW = count_width(WIN_LOG2);
    localparam logic [CW-1:0] THRESH = CW'(MARK_MIN);

    logic                sync1_reg;
    logic                sync2_reg;
    logic [WIN_LOG2-1:0] pos_reg;
    logic [CW-1:0]       count_reg;
    logic [CW-1:0]       count_next;
    logic                mark_reg;
    logic                win_end_reg;
    logic                last_clk;

    assign last_clk   = &pos_reg;
    // The sample arriving on the last clock still belongs to the closing window.
    assign count_next = count_reg + CW'(sync2_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            pos_reg     <= '0;
            count_reg   <= '0;
            mark_reg    <= 1'b0;
            win_end_reg <= 1'b0;
        end else begin
            sync1_reg   <= rf_in;
            sync2_reg   <= sync1_reg;
            pos_reg     <= pos_reg + 1'b1;
            win_end_reg <= last_clk;
            if (last_clk) begin
                mark_reg  <= (count_next >= THRESH);
                count_reg <= '0;
            end else begin
                count_reg <= count_next;
            end
        end
    end

    assign mark    = mark_reg;
    assign win_end = win_end_reg;

endmodule

// File: rtl/am_key_receiver.sv
// AM key-leak receiver: locks to per-bit sync beeps and votes each data bit from slot 2.
// Optional AM_RX_DEGLITCH_EN: feed the FSM a two-window-agreement filtered mark.
module am_key_receiver
    import am_rx_pkg::*;
#(
    parameter int KEY_W     = 56,
    parameter int WIN_LOG2  = 16,
    parameter int SLOT_LOG2 = 23,
    parameter int MARK_MIN  = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rf_in,
    output logic                       locked,
    output logic [$clog2(KEY_W+1)-1:0] bit_cnt,
    output logic [KEY_W-1:0]           key_out,
    output logic                       key_valid
);

    localparam int W  = 1 << (SLOT_LOG2 - WIN_LOG2);
    localparam int IW = idx_width(SLOT_LOG2, WIN_LOG2);
    localparam int VW = vote_width(W);
    localparam int BW = $clog2(KEY_W + 1);

    localparam logic [IW-1:0] SYNC_BEGIN = IW'(SYNC_SLOT * W);
    localparam logic [IW-1:0] SYNC_END   = IW'(SYNC_SLOT * W + W - 1);
    localparam logic [IW-1:0] DATA_BEGIN = IW'(DATA_SLOT * W);
    localparam logic [IW-1:0] DATA_END   = IW'(DATA_SLOT * W + W - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(SLOTS_PER_BIT * W - 1);
    localparam logic [VW-1:0] VOTE_HALF  = VW'(W / 2);
    localparam logic [VW-1:0] VOTE_MAX   = VW'(W);
    localparam logic [BW-1:0] LAST_BIT   = BW'(KEY_W - 1);

    logic mark_raw;
    logic win_end;
    logic mark;

    am_carrier_detect #(
        .WIN_LOG2 (WIN_LOG2),
        .MARK_MIN (MARK_MIN)
    ) u_detect (
        .clk     (clk),
        .rst     (rst),
        .rf_in   (rf_in),
        .mark    (mark_raw),
        .win_end (win_end)
    );

`ifdef AM_RX_DEGLITCH_EN
    logic raw_prev_reg;
    logic filt_reg;

    // Level filter: the output only follows the raw mark once two windows agree.
    assign mark = (mark_raw == raw_prev_reg) ? mark_raw : filt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_prev_reg <= 1'b0;
            filt_reg     <= 1'b0;
        end else if (win_end) begin
            raw_prev_reg <= mark_raw;
            filt_reg     <= mark;
        end
    end
`else
    assign mark = mark_raw;
`endif

    rx_state_t        state_reg;
    rx_state_t        state_next;
    logic [IW-1:0]    win_idx_reg;
    logic [VW-1:0]    sync_cnt_reg;
    logic [VW-1:0]    data_cnt_reg;
    logic [BW-1:0]    bit_cnt_reg;
    logic [KEY_W-2:0] partial_reg;
    logic [KEY_W-1:0] key_reg;
    logic             locked_reg;
    logic             key_valid_reg;
    logic             prev_mark_reg;

    logic [VW-1:0] sync_total;
    logic [VW-1:0] data_total;
    logic          in_sync;
    logic          in_data;
    logic          new_bit;
    logic          do_lock;
    logic          sync_fail;
    logic          take_bit;
    logic          frame_done;

    // Each slot's vote restarts on its first window, so no explicit clear is needed.
    assign sync_total = (win_idx_reg == SYNC_BEGIN) ? VW'(mark) :
                        (sync_cnt_reg == VOTE_MAX)  ? VOTE_MAX  : sync_cnt_reg + VW'(mark);
    assign data_total = (win_idx_reg == DATA_BEGIN) ? VW'(mark) :
                        (data_cnt_reg == VOTE_MAX)  ? VOTE_MAX  : data_cnt_reg + VW'(mark);
    assign in_sync    = (win_idx_reg <= SYNC_END);
    assign in_data    = (win_idx_reg >= DATA_BEGIN) && (win_idx_reg <= DATA_END);
    assign new_bit    = (data_total > VOTE_HALF);

    always_comb begin
        state_next = state_reg;
        do_lock    = 1'b0;
        sync_fail  = 1'b0;
        take_bit   = 1'b0;
        frame_done = 1'b0;
        if (win_end) begin
            case (state_reg)
                HUNT: begin
                    if (mark && !prev_mark_reg) begin
                        do_lock    = 1'b1;
                        state_next = RX;
                    end
                end
                RX, DONE: begin
                    if (win_idx_reg == SYNC_END && sync_total <= VOTE_HALF) begin
                        sync_fail  = 1'b1;
                        state_next = HUNT;
                    end else if (state_reg == RX && win_idx_reg == DATA_END) begin
                        take_bit = 1'b1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            frame_done = 1'b1;
                            state_next = DONE;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_idx_reg   <= '0;
            sync_cnt_reg  <= '0;
            data_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            partial_reg   <= '0;
            key_reg       <= '0;
            locked_reg    <= 1'b0;
            key_valid_reg <= 1'b0;
            prev_mark_reg <= 1'b0;
        end else begin
            key_valid_reg <= 1'b0;
            if (win_end) begin
                prev_mark_reg <= mark;
                if (do_lock) begin
                    win_idx_reg  <= IW'(1);
                    sync_cnt_reg <= VW'(1);
                    data_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    partial_reg  <= '0;
                    locked_reg   <= 1'b1;
                end else if (sync_fail) begin
                    win_idx_reg  <= '0;
                    sync_cnt_reg <= '0;
                    data_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    partial_reg  <= '0;
                    locked_reg   <= 1'b0;
                end else if (state_reg != HUNT) begin
                    win_idx_reg <= (win_idx_reg == IDX_LAST) ? '0 : win_idx_reg + 1'b1;
                    if (in_sync) begin
                        sync_cnt_reg <= sync_total;
                    end
                    if (in_data) begin
                        data_cnt_reg <= data_total;
                    end
                    // Bits enter at the MSB, so the first bit on air ends up at key bit 0.
                    if (take_bit) begin
                        partial_reg <= {new_bit, partial_reg[KEY_W-2:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                    if (frame_done) begin
                        key_reg       <= {new_bit, partial_reg};
                        key_valid_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign locked    = locked_reg;
    assign bit_cnt   = bit_cnt_reg;
    assign key_out   = key_reg;
    assign key_valid = key_valid_reg;

endmodule

// File: tb/tb_am_key_receiver.sv
// Directed bench for am_key_receiver: table of whole-frame vectors plus burst and reset sequences.
module tb_am_key_receiver;

    localparam int KEY_W     = 56;
    localparam int WIN_LOG2  = 2;
    localparam int SLOT_LOG2 = 4;
    localparam int MARK_MIN  = 2;
    localparam int SLOT_CLK  = 1 << SLOT_LOG2;
    localparam int BIT_CLK   = 8 * SLOT_CLK;

    logic             clk = 1'b0;
    logic             rst;
    logic             rf_in;
    logic             locked;
    logic [5:0]       bit_cnt;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;

    int n_vec      = 0;
    int n_bad      = 0;
    int valid_seen = 0;

    am_key_receiver #(
        .KEY_W     (KEY_W),
        .WIN_LOG2  (WIN_LOG2),
        .SLOT_LOG2 (SLOT_LOG2),
        .MARK_MIN  (MARK_MIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rf_in     (rf_in),
        .locked    (locked),
        .bit_cnt   (bit_cnt),
        .key_out   (key_out),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid === 1'b1) valid_seen++;
    end

    typedef struct {
        logic [KEY_W-1:0] key;
        int               omit;
        int               trail;
        int               exp_valid;
        logic [KEY_W-1:0] exp_key;
        int               exp_bits;
        logic             exp_locked;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One bit period of the transmitter, truncated to nclk clocks; carrier toggles during beeps.
    task automatic tx_bit(input logic sync_on, input logic data, input int nclk);
        for (int c = 0; c < nclk; c++) begin
            @(negedge clk);
            rf_in = (((c / SLOT_CLK) == 0 && sync_on) || ((c / SLOT_CLK) == 2 && data)) && (c % 2 == 1);
        end
    endtask

    task automatic tx_silence(input int nbits);
        for (int b = 0; b < nbits; b++) tx_bit(1'b0, 1'b0, BIT_CLK);
    endtask

    task automatic send_frame(input logic [KEY_W-1:0] key, input int omit, input int trail);
        for (int i = 0; i < KEY_W; i++) begin
            if (i == omit) begin
                check("pre_omit_locked", 64'(locked), 64'd1);
                check("pre_omit_bits", 64'(bit_cnt), 64'(omit));
                tx_bit(1'b0, 1'b0, BIT_CLK);
                check("omit_locked", 64'(locked), 64'd0);
                return;
            end
            tx_bit(1'b1, key[i], BIT_CLK);
        end
        for (int t = 0; t < trail; t++) tx_bit(1'b1, 1'b0, BIT_CLK);
    endtask

    initial begin
        int   v0;
        logic saw;

        vecs[0] = '{56'hA50F3C96123456, -1, 3, 1, 56'hA50F3C96123456, 56, 1'b1};
        vecs[1] = '{56'h0,              -1, 0, 1, 56'h0,              56, 1'b1};
        vecs[2] = '{56'h1,              10, 0, 0, 56'h0,               0, 1'b0};
        vecs[3] = '{56'h1,              -1, 0, 1, 56'h1,              56, 1'b1};

        rst   = 1'b1;
        rf_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_bit_cnt", 64'(bit_cnt), 64'd0);
        check("rst_key_out", 64'(key_out), 64'd0);
        check("rst_key_valid", 64'(key_valid), 64'd0);
        rst = 1'b0;

        // A single-window burst of carrier in silence.
        tx_silence(1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rf_in = 1'b1;
        end
        @(negedge clk);
        rf_in = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (locked === 1'b1) saw = 1'b1;
        end
`ifdef AM_RX_DEGLITCH_EN
        check("burst_lock_seen", 64'(saw), 64'd0);
`else
        check("burst_lock_seen", 64'(saw), 64'd1);
`endif
        check("burst_locked_end", 64'(locked), 64'd0);
        $display("burst: lock_seen=%0b locked=%0b", saw, locked);
        tx_silence(1);

        for (int i = 0; i < 4; i++) begin
            v0 = valid_seen;
            send_frame(vecs[i].key, vecs[i].omit, vecs[i].trail);
            check($sformatf("v%0d_valid_count", i), 64'(valid_seen - v0), 64'(vecs[i].exp_valid));
            check($sformatf("v%0d_key_out", i), 64'(key_out), 64'(vecs[i].exp_key));
            check($sformatf("v%0d_bit_cnt", i), 64'(bit_cnt), 64'(vecs[i].exp_bits));
            check($sformatf("v%0d_locked", i), 64'(locked), 64'(vecs[i].exp_locked));
            $display("vec %0d: key=%h valid=%0d key_out=%h bit_cnt=%0d locked=%0b",
                     i, vecs[i].key, valid_seen - v0, key_out, bit_cnt, locked);
            tx_silence(2);
            check($sformatf("v%0d_idle_locked", i), 64'(locked), 64'd0);
            check($sformatf("v%0d_idle_key", i), 64'(key_out), 64'(vecs[i].exp_key));
        end

        // Asynchronous reset in the middle of bit 20.
        begin
            logic [KEY_W-1:0] k2;
            k2 = 56'hDEADBEEFCAFE12;
            for (int i = 0; i < 20; i++) tx_bit(1'b1, k2[i], BIT_CLK);
            tx_bit(1'b1, k2[20], 30);
            check("pre_rst_bits", 64'(bit_cnt), 64'd20);
            check("pre_rst_locked", 64'(locked), 64'd1);
            #2;
            rst   = 1'b1;
            rf_in = 1'b0;
            #1;
            check("async_rst_locked", 64'(locked), 64'd0);
            check("async_rst_bit_cnt", 64'(bit_cnt), 64'd0);
            check("async_rst_key_out", 64'(key_out), 64'd0);
            check("async_rst_key_valid", 64'(key_valid), 64'd0);
            $display("rst: locked=%0b bit_cnt=%0d key_out=%h", locked, bit_cnt, key_out);
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end

        tx_silence(1);
        v0 = valid_seen;
        send_frame(56'h0123456789ABCD, -1, 0);
        check("fresh_valid_count", 64'(valid_seen - v0), 64'd1);
        check("fresh_key_out", 64'(key_out), 64'h0123456789ABCD);
        check("fresh_bit_cnt", 64'(bit_cnt), 64'd56);
        check("fresh_locked", 64'(locked), 64'd1);
        $display("fresh: valid=%0d key_out=%h bit_cnt=%0d locked=%0b",
                 valid_seen - v0, key_out, bit_cnt, locked);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
